// File: rtl/gb_dma_arbiter.sv
// OAM DMA controller and CPU/DMA arbiter for the single shared memory bus.
// Owns FF46: a write there copies 160 bytes from {src_hi, 8'h00} into OAM at FE00.
module gb_dma_arbiter #(
    parameter int unsigned DMA_LEN  = 160,
    parameter logic [15:0] DST_BASE = 16'hFE00,
    parameter logic [15:0] REG_ADDR = 16'hFF46,
    parameter logic [7:0]  OPEN_BUS = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr_i,
    input  logic [7:0]  cpu_data_i,
    input  logic        cpu_we_i,
    output logic [7:0]  cpu_data_o,
    output logic [15:0] bus_addr_o,
    output logic [7:0]  bus_data_o,
    output logic        bus_we_o,
    input  logic [7:0]  bus_data_i,
    output logic        dma_active_o
);

    localparam logic [7:0] LastIdx = 8'(DMA_LEN - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StRead,
        StWrite
    } state_e;

    state_e      state_q;
    logic [7:0]  idx_q;
    logic [7:0]  byte_q;
    logic [7:0]  src_hi_q;
    logic        dma_active_q;

    logic        reg_sel;
    logic        reg_wr;
    logic [7:0]  eff_hi;

    assign reg_sel = (cpu_addr_i == REG_ADDR);
    assign reg_wr  = cpu_we_i && reg_sel;

    // Echo RAM (E000-FDFF) aliases C000-DDFF, so fold the source page down.
    assign eff_hi = (src_hi_q >= 8'hE0) ? (src_hi_q & 8'hDF) : src_hi_q;

    assign dma_active_o = dma_active_q;

    // Transfer sequencer; a register write in any non-idle state restarts via StStart.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            idx_q        <= 8'h00;
            byte_q       <= 8'h00;
            src_hi_q     <= 8'h00;
            dma_active_q <= 1'b0;
        end else begin
            if (reg_wr) begin
                src_hi_q <= cpu_data_i;
            end
            unique case (state_q)
                StIdle: begin
                    dma_active_q <= 1'b0;
                    if (reg_wr) begin
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    idx_q <= 8'h00;
                    if (reg_wr) begin
                        state_q      <= StStart;
                        dma_active_q <= 1'b0;
                    end else begin
                        state_q      <= StRead;
                        dma_active_q <= 1'b1;
                    end
                end
                StRead: begin
                    byte_q <= bus_data_i;
                    if (reg_wr) begin
                        state_q      <= StStart;
                        dma_active_q <= 1'b0;
                    end else begin
                        state_q <= StWrite;
                    end
                end
                StWrite: begin
                    if (reg_wr) begin
                        state_q      <= StStart;
                        dma_active_q <= 1'b0;
                    end else if (idx_q == LastIdx) begin
                        state_q      <= StIdle;
                        dma_active_q <= 1'b0;
                    end else begin
                        idx_q   <= idx_q + 8'h01;
                        state_q <= StRead;
                    end
                end
                default: begin
                    state_q      <= StIdle;
                    dma_active_q <= 1'b0;
                end
            endcase
        end
    end

    // Bus mux: CPU pass-through unless the DMA owns the bus; FF46 never reaches the bus.
    always_comb begin
        bus_addr_o = cpu_addr_i;
        bus_data_o = cpu_data_i;
        bus_we_o   = cpu_we_i && !reg_sel;
        cpu_data_o = reg_sel ? src_hi_q : bus_data_i;
        unique case (state_q)
            StRead: begin
                bus_addr_o = {eff_hi, idx_q};
                bus_data_o = byte_q;
                bus_we_o   = 1'b0;
                cpu_data_o = reg_sel ? src_hi_q : OPEN_BUS;
            end
            StWrite: begin
                bus_addr_o = DST_BASE + {8'h00, idx_q};
                bus_data_o = byte_q;
                bus_we_o   = 1'b1;
                cpu_data_o = reg_sel ? src_hi_q : OPEN_BUS;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_gb_dma_arbiter.sv
// Bench for gb_dma_arbiter: flat 64 KiB memory on the bus, a window-based model of the
// DMA schedule checked every cycle, plus directed scenarios with literal expectations.
module tb_gb_dma_arbiter;

    localparam int          DMA_LEN = 160;
    localparam logic [15:0] REG     = 16'hFF46;
    localparam int          PC0 = 0, PC1 = 1, PD0 = 2, PE1 = 3, PFILL = 4;

    logic        clk;
    logic        reset;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic        cpu_we;
    logic [7:0]  cpu_data_o;
    logic [15:0] bus_addr_o;
    logic [7:0]  bus_data_o;
    logic        bus_we_o;
    logic [7:0]  bus_data_i;
    logic        dma_active_o;

    logic [7:0] mem [0:65535];

    int cyc = 0;
    int n_pass = 0;
    int n_total = 0;

    // Model: the register value and the cycle at which the current copy window opens.
    logic [7:0] m_src = 8'h00;
    int         m_ws = -1;

    int   act_cnt = 0;
    int   total_we = 0;
    int   rise_cyc = -1;
    logic prev_act = 1'b0;

    gb_dma_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_addr_i   (cpu_addr),
        .cpu_data_i   (cpu_data),
        .cpu_we_i     (cpu_we),
        .cpu_data_o   (cpu_data_o),
        .bus_addr_o   (bus_addr_o),
        .bus_data_o   (bus_data_o),
        .bus_we_o     (bus_we_o),
        .bus_data_i   (bus_data_i),
        .dma_active_o (dma_active_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus_data_i = mem[bus_addr_o];

    always @(posedge clk) begin
        if (bus_we_o) mem[bus_addr_o] <= bus_data_o;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // A write to FF46 seen at an edge makes the next cycle setup and opens a
    // 2*DMA_LEN-cycle window the cycle after that; reset abandons everything.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_src <= 8'h00;
            m_ws  <= -1;
        end else if (cpu_we && cpu_addr == REG) begin
            m_src <= cpu_data;
            m_ws  <= cyc + 2;
        end
    end

    always @(negedge clk) begin
        if (dma_active_o) act_cnt <= act_cnt + 1;
        if (dma_active_o && !prev_act) rise_cyc <= cyc;
        if (dma_active_o && bus_we_o) total_we <= total_we + 1;
        prev_act <= dma_active_o;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running at cyc %0d, required finish", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h, required %0h (cyc %0d)", name, got, want, cyc);
    endtask

    function automatic logic [7:0] pat(input int kind, input int i);
        logic [7:0] b;
        b = 8'(i);
        case (kind)
            PC0:     return b ^ 8'h5A;
            PC1:     return b ^ 8'hA5;
            PD0:     return ~b;
            PE1:     return b + 8'h11;
            default: return 8'hEE;
        endcase
    endfunction

    function automatic int count_bad(input logic [15:0] base, input int n, input int kind,
                                     input int off);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            if (mem[base + 16'(i)] !== pat(kind, i + off)) bad++;
        end
        return bad;
    endfunction

    // Per-cycle comparison of every DUT output against the window model.
    task automatic compare_cycle();
        bit          act;
        int          t;
        logic [7:0]  eff, i8, cd_e, bd_e;
        logic [15:0] ea;
        logic        we_e;
        act = (m_ws >= 0) && (cyc >= m_ws) && (cyc < m_ws + 2 * DMA_LEN);
        eff = (m_src >= 8'hE0) ? m_src - 8'h20 : m_src;
        if (act) begin
            t    = cyc - m_ws;
            i8   = 8'(t / 2);
            cd_e = (cpu_addr == REG) ? m_src : 8'hFF;
            if (t % 2 == 0) begin
                ea   = {eff, i8};
                we_e = 1'b0;
                chk("rd_addr", bus_addr_o, ea);
            end else begin
                ea   = 16'hFE00 + 16'(t / 2);
                we_e = 1'b1;
                bd_e = mem[{eff, i8}];
                chk("wr_addr", bus_addr_o, ea);
                chk("wr_data", bus_data_o, bd_e);
            end
        end else begin
            we_e = cpu_we && (cpu_addr != REG);
            cd_e = (cpu_addr == REG) ? m_src : mem[cpu_addr];
            chk("pt_addr", bus_addr_o, cpu_addr);
            chk("pt_data", bus_data_o, cpu_data);
        end
        chk("active", dma_active_o, act);
        chk("bus_we", bus_we_o, we_e);
        chk("cpu_rd", cpu_data_o, cd_e);
    endtask

    task automatic step();
        @(negedge clk);
        compare_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) step();
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        cpu_addr = a;
        cpu_data = d;
        cpu_we   = 1'b1;
        step();
        cpu_we   = 1'b0;
        cpu_addr = 16'h0000;
        cpu_data = 8'h00;
    endtask

    task automatic fill(input logic [15:0] base, input int kind);
        for (int i = 0; i < DMA_LEN; i++) cpu_write(base + 16'(i), pat(kind, i));
    endtask

    initial begin
        int c, c2, a0, w0, w1;
        reset    = 1'b0;
        cpu_addr = REG;
        cpu_data = 8'h00;
        cpu_we   = 1'b0;
        #3;
        chk("rst_active", dma_active_o, 1'b0);
        chk("rst_ff46", cpu_data_o, 8'h00);
        chk("rst_passthru", bus_addr_o, REG);
        @(posedge clk);
        #1;
        reset = 1'b1;
        step();

        fill(16'hC000, PC0);
        fill(16'hC100, PC1);
        fill(16'hE100, PE1);
        fill(16'hD000, PD0);

        // Basic copy with CPU traffic during the transfer.
        fill(16'hFE00, PFILL);
        a0 = act_cnt;
        w0 = total_we;
        c  = cyc;
        cpu_write(REG, 8'hC0);
        wait_until(c + 62);
        cpu_addr = 16'hC000;
        #1;
        chk("dma_rd_openbus", cpu_data_o, 8'hFF);
        cpu_addr = REG;
        #1;
        chk("dma_rd_ff46", cpu_data_o, 8'hC0);
        cpu_write(16'hC010, 8'h77);
        wait_until(c + 2 + 2 * DMA_LEN);
        chk("basic_act_len", act_cnt - a0, 320);
        chk("basic_rise", rise_cyc, c + 2);
        chk("basic_we_cnt", total_we - w0, 160);
        chk("basic_idle", dma_active_o, 1'b0);
        chk("basic_fe_bad", count_bad(16'hFE00, DMA_LEN, PC0, 0), 0);
        chk("basic_fe05", mem[16'hFE05], 8'h5F);
        cpu_addr = 16'hC010;
        #1;
        chk("dropped_write", cpu_data_o, 8'h4A);
        step();

        // Echo source page E1 folds onto C1.
        fill(16'hFE00, PFILL);
        c = cyc;
        cpu_write(REG, 8'hE1);
        wait_until(c + 40);
        cpu_addr = REG;
        #1;
        chk("echo_ff46", cpu_data_o, 8'hE1);
        wait_until(c + 2 + 2 * DMA_LEN);
        chk("echo_fe_bad", count_bad(16'hFE00, DMA_LEN, PC1, 0), 0);
        chk("echo_fe00", mem[16'hFE00], 8'hA5);

        // Restart at byte 50.
        fill(16'hFE00, PFILL);
        c = cyc;
        cpu_write(REG, 8'hC0);
        wait_until(c + 102);
        c2 = cyc;
        cpu_write(REG, 8'hD0);
        a0 = act_cnt;
        chk("rst50_old_bad", count_bad(16'hFE00, 50, PC0, 0), 0);
        chk("rst50_untouched", count_bad(16'hFE32, DMA_LEN - 50, PFILL, 0), 0);
        wait_until(c2 + 2 + 2 * DMA_LEN);
        chk("restart_rise", rise_cyc, c2 + 2);
        chk("restart_act_len", act_cnt - a0, 320);
        chk("restart_fe_bad", count_bad(16'hFE00, DMA_LEN, PD0, 0), 0);
        chk("restart_fe9f", mem[16'hFE9F], 8'h60);

        // Reset asserted during the read of byte 80.
        fill(16'hFE00, PFILL);
        c = cyc;
        cpu_write(REG, 8'hC0);
        wait_until(c + 162);
        cpu_addr = REG;
        reset    = 1'b0;
        #1;
        chk("midrst_active", dma_active_o, 1'b0);
        chk("midrst_ff46", cpu_data_o, 8'h00);
        chk("midrst_addr", bus_addr_o, REG);
        step();
        step();
        reset = 1'b1;
        step();
        chk("midrst_done_bad", count_bad(16'hFE00, 80, PC0, 0), 0);
        chk("midrst_rest_bad", count_bad(16'hFE50, 80, PFILL, 0), 0);
        cpu_write(16'hC200, 8'h33);
        cpu_addr = 16'hC200;
        #1;
        chk("post_rst_passthru", cpu_data_o, 8'h33);
        step();

        // Back-to-back copies.
        fill(16'hFE00, PFILL);
        w0 = total_we;
        c  = cyc;
        cpu_write(REG, 8'hC0);
        wait_until(c + 322);
        chk("b2b_we_first", total_we - w0, 160);
        chk("b2b_fe_first", count_bad(16'hFE00, DMA_LEN, PC0, 0), 0);
        w1 = total_we;
        c2 = cyc;
        cpu_write(REG, 8'hD0);
        wait_until(c2 + 322);
        chk("b2b_we_second", total_we - w1, 160);
        chk("b2b_rise", rise_cyc, c2 + 2);
        chk("b2b_fe_second", count_bad(16'hFE00, DMA_LEN, PD0, 0), 0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
